laser_search_ctrl: RTL and testbench



---
 rtl/laser_pkg.sv | 20 ++
 rtl/laser_search_ctrl_if.sv | 25 ++
 rtl/laser_cand_scan.sv | 66 ++++++
 rtl/laser_search_ctrl.sv | 159 +++++++++++++++
 tb/tb_laser_search_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER two-circle coverage search.
// Coordinates index a GRID x GRID candidate grid; counts cover 0..NUM_PTS.
package laser_pkg;

   typedef logic [3:0] coord_t;
   typedef logic [5:0] count_t;

   localparam int     NUM_PTS   = 40;
   localparam int     GRID      = 16;
   localparam coord_t GRID_LAST = coord_t'(GRID - 1);

   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      SCAN     = 3'd1,
      WAIT     = 3'd2,
      NEXTPASS = 3'd3,
      FINISH   = 3'd4
   } state_t;

endpackage

// File: rtl/laser_search_ctrl_if.sv
// Request/response handshake between the search sequencer and the external
// coverage-count engine. One request is outstanding at most.
interface laser_search_ctrl_if;
   import laser_pkg::*;

   logic   req_valid;
   logic   req_ready;
   coord_t req_cx;
   coord_t req_cy;
   coord_t req_ox;
   coord_t req_oy;
   logic   resp_valid;
   count_t resp_count;

   modport master (
      output req_valid, req_cx, req_cy, req_ox, req_oy,
      input  req_ready, resp_valid, resp_count
   );

   modport slave (
      input  req_valid, req_cx, req_cy, req_ox, req_oy,
      output req_ready, resp_valid, resp_count
   );

endinterface

// File: rtl/laser_cand_scan.sv
// Row-major candidate walker plus the best-count / pending-centre tracker.
// Only a strictly greater count replaces the pending centre, so ties keep the earlier candidate.
module laser_cand_scan
   import laser_pkg::*;
(
   input  logic   CLK,
   input  logic   RST_N,
   input  logic   clear,
   input  logic   start,
   input  coord_t start_x,
   input  coord_t start_y,
   input  logic   resp_fire,
   input  count_t resp_count,
   output coord_t cand_x,
   output coord_t cand_y,
   output logic   last_cand,
   output coord_t pend_x,
   output coord_t pend_y,
   output logic   improved
);

   count_t best;

   assign last_cand = (cand_x == GRID_LAST) && (cand_y == GRID_LAST);
   assign improved  = resp_fire && (resp_count > best);

   // The walker wraps to (0,0) after the last candidate, ready for the next pass.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cand_x <= '0;
         cand_y <= '0;
      end else if (clear) begin
         cand_x <= '0;
         cand_y <= '0;
      end else if (resp_fire) begin
         if (cand_x == GRID_LAST) begin
            cand_x <= '0;
            cand_y <= last_cand ? coord_t'(0) : cand_y + 1'b1;
         end else begin
            cand_x <= cand_x + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         best   <= '0;
         pend_x <= '0;
         pend_y <= '0;
      end else begin
         if (clear)
            best <= '0;
         else if (improved)
            best <= resp_count;

         if (start) begin
            pend_x <= start_x;
            pend_y <= start_y;
         end else if (improved) begin
            pend_x <= cand_x;
            pend_y <= cand_y;
         end
      end
   end

endmodule

// File: rtl/laser_search_ctrl.sv
// Top-level LASER sequencer: loads the point buffer, then alternates full-grid
// scans for C1 and C2 through the coverage engine until convergence or MAX_PASS.
module laser_search_ctrl
   import laser_pkg::*;
#(
   parameter int MAX_PASS = 8
)(
   input  logic                 CLK,
   input  logic                 RST_N,
   input  coord_t               X,
   input  coord_t               Y,
   output logic                 pt_we,
   output logic [5:0]           pt_addr,
   output coord_t               pt_x,
   output coord_t               pt_y,
   laser_search_ctrl_if.master  eng,
   output coord_t               C1X,
   output coord_t               C1Y,
   output coord_t               C2X,
   output coord_t               C2Y,
   output logic                 DONE
);

   localparam logic [3:0] PASS_LIMIT = 4'(MAX_PASS);

   state_t     state;
   logic [5:0] ld_cnt;
   logic [3:0] pass_cnt, idle_cnt, pass_next, idle_next;
   logic       pass_improved, finish_now;
   coord_t     w1_x, w1_y, w2_x, w2_y;
   coord_t     cand_x, cand_y, pend_x, pend_y, start_x, start_y;
   logic       last_cand, improved, resp_fire, clear, start;

   assign resp_fire  = (state == WAIT) && eng.resp_valid;
   assign clear      = (state == LOAD);
   assign start      = (state == LOAD) || (state == NEXTPASS);
   assign pass_next  = pass_cnt + 4'd1;
   assign idle_next  = pass_improved ? 4'd0 : idle_cnt + 4'd1;
   assign finish_now = (idle_next == 4'd2) || (pass_next == PASS_LIMIT);

   // Odd passes move W2 against a fixed W1; even passes move W1 against W2.
   always_comb begin
      start_x = w1_x;
      start_y = w1_y;
      if (state == LOAD) begin
         start_x = '0;
         start_y = '0;
      end else if (pass_next[0]) begin
         start_x = w2_x;
         start_y = w2_y;
      end
   end

   assign eng.req_valid = (state == SCAN);
   assign eng.req_cx    = cand_x;
   assign eng.req_cy    = cand_y;
   assign eng.req_ox    = pass_cnt[0] ? w1_x : w2_x;
   assign eng.req_oy    = pass_cnt[0] ? w1_y : w2_y;

   laser_cand_scan u_cand_scan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .clear      (clear),
      .start      (start),
      .start_x    (start_x),
      .start_y    (start_y),
      .resp_fire  (resp_fire),
      .resp_count (eng.resp_count),
      .cand_x     (cand_x),
      .cand_y     (cand_y),
      .last_cand  (last_cand),
      .pend_x     (pend_x),
      .pend_y     (pend_y),
      .improved   (improved)
   );

   // LOAD spends NUM_PTS cycles writing and one more before the first request.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= LOAD;
         ld_cnt        <= '0;
         pt_we         <= 1'b0;
         pt_addr       <= '0;
         pt_x          <= '0;
         pt_y          <= '0;
         pass_cnt      <= '0;
         idle_cnt      <= '0;
         pass_improved <= 1'b0;
         w1_x          <= '0;
         w1_y          <= '0;
         w2_x          <= GRID_LAST;
         w2_y          <= GRID_LAST;
         C1X           <= '0;
         C1Y           <= '0;
         C2X           <= '0;
         C2Y           <= '0;
         DONE          <= 1'b0;
      end else begin
         pt_we <= 1'b0;
         DONE  <= 1'b0;
         case (state)
            LOAD: begin
               w1_x          <= '0;
               w1_y          <= '0;
               w2_x          <= GRID_LAST;
               w2_y          <= GRID_LAST;
               pass_cnt      <= '0;
               idle_cnt      <= '0;
               pass_improved <= 1'b0;
               if (ld_cnt == 6'(NUM_PTS)) begin
                  state <= SCAN;
               end else begin
                  pt_we   <= 1'b1;
                  pt_addr <= ld_cnt;
                  pt_x    <= X;
                  pt_y    <= Y;
                  ld_cnt  <= ld_cnt + 6'd1;
               end
            end
            SCAN: begin
               if (eng.req_ready)
                  state <= WAIT;
            end
            WAIT: begin
               if (eng.resp_valid) begin
                  if (improved)
                     pass_improved <= 1'b1;
                  state <= last_cand ? NEXTPASS : SCAN;
               end
            end
            NEXTPASS: begin
               if (pass_cnt[0]) begin
                  w2_x <= pend_x;
                  w2_y <= pend_y;
               end else begin
                  w1_x <= pend_x;
                  w1_y <= pend_y;
               end
               pass_cnt      <= pass_next;
               idle_cnt      <= idle_next;
               pass_improved <= 1'b0;
               state         <= finish_now ? FINISH : SCAN;
            end
            FINISH: begin
               C1X     <= w1_x;
               C1Y     <= w1_y;
               C2X     <= w2_x;
               C2Y     <= w2_y;
               DONE    <= 1'b1;
               ld_cnt  <= '0;
               pt_addr <= '0;
               state   <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Directed bench for laser_search_ctrl: a stub coverage engine answers requests
// from a per-scenario table, and each test task checks its own expected results.
module tb_laser_search_ctrl;
   import laser_pkg::*;

   logic       CLK = 1'b0;
   logic       RST_N;
   coord_t     X, Y;
   logic       pt_we;
   logic [5:0] pt_addr;
   coord_t     pt_x, pt_y, C1X, C1Y, C2X, C2Y;
   logic       DONE;

   laser_search_ctrl_if eng ();

   laser_search_ctrl #(.MAX_PASS(8)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .X       (X),
      .Y       (Y),
      .pt_we   (pt_we),
      .pt_addr (pt_addr),
      .pt_x    (pt_x),
      .pt_y    (pt_y),
      .eng     (eng),
      .C1X     (C1X),
      .C1Y     (C1Y),
      .C2X     (C2X),
      .C2Y     (C2Y),
      .DONE    (DONE)
   );

   always #5 CLK = ~CLK;

   int     tests_run = 0;
   int     tests_failed = 0;
   int     mode = 0;
   bit     stall_en = 1'b0;
   int     req_num = 0;
   int     viol_outstanding = 0;
   int     viol_stable = 0;
   coord_t other_x [16];
   coord_t other_y [16];

   // Scenario table: 0 = single peak at (5,5), 1 = constant 7, 2 = diagonal per pass.
   function automatic count_t model(input coord_t cx, input coord_t cy, input int p);
      case (mode)
         0:       return (cx == 4'd5 && cy == 4'd5) ? 6'd10 : 6'd0;
         1:       return 6'd7;
         default: return (int'(cx) == p && int'(cy) == p) ? count_t'(4 * (p + 1)) : 6'd0;
      endcase
   endfunction

   // Engine stub works on falling edges so its view is stable for the next rising edge.
   initial begin : engine_stub
      bit     pending, fire, was_stalled;
      int     delay, p;
      count_t val;
      coord_t lcx, lcy, lox, loy;
      pending = 0; fire = 0; was_stalled = 0; delay = 0; val = '0;
      lcx = '0; lcy = '0; lox = '0; loy = '0;
      eng.req_ready = 1'b0; eng.resp_valid = 1'b0; eng.resp_count = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            pending = 0; fire = 0; was_stalled = 0;
            eng.resp_valid = 1'b0;
            eng.req_ready  = 1'b0;
         end else begin
            if (was_stalled && (eng.req_valid !== 1'b1 || eng.req_cx !== lcx || eng.req_cy !== lcy ||
                                eng.req_ox !== lox || eng.req_oy !== loy))
               viol_stable++;
            if (fire) begin
               p = req_num / (GRID * GRID);
               if (req_num % (GRID * GRID) == 0 && p < 16) begin
                  other_x[p] = lox;
                  other_y[p] = loy;
               end
               val = model(lcx, lcy, p);
               req_num++;
               pending = 1;
               delay = stall_en ? int'($urandom_range(0, 5)) : 0;
            end
            eng.resp_valid = 1'b0;
            if (pending) begin
               if (delay == 0) begin
                  eng.resp_valid = 1'b1;
                  eng.resp_count = val;
                  pending = 0;
               end else begin
                  delay--;
               end
            end
            eng.req_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (eng.req_valid && (pending || eng.resp_valid))
               viol_outstanding++;
            fire        = eng.req_valid && eng.req_ready;
            was_stalled = eng.req_valid && !eng.req_ready;
            lcx = eng.req_cx; lcy = eng.req_cy; lox = eng.req_ox; loy = eng.req_oy;
         end
      end
   end

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   endtask

   // Streams one pattern; called on the falling edge just before the first sampling edge.
   task automatic load_points(input int seed);
      req_num = 0;
      for (int i = 0; i < NUM_PTS; i++) begin
         coord_t ex, ey;
         ex = coord_t'((i * 3 + seed) % 16);
         ey = coord_t'((i * 7 + seed * 5 + 1) % 16);
         X = ex;
         Y = ey;
         @(negedge CLK);
         tests_run++;
         if (pt_we !== 1'b1 || pt_addr !== 6'(i) || pt_x !== ex || pt_y !== ey || eng.req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_pt%0d: got we=%b addr=%0d x=%0d y=%0d req_valid=%b, want we=1 addr=%0d x=%0d y=%0d req_valid=0",
                     i, pt_we, pt_addr, pt_x, pt_y, eng.req_valid, i, ex, ey);
         end
         if (i == 0) begin
            tests_run++;
            if (DONE !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL done_width: got DONE=%b one cycle later, want 0", DONE);
            end
         end
      end
      X = '0;
      Y = '0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b1;
      X = '0;
      Y = '0;
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      tests_run++;
      if (pt_we !== 1'b0 || pt_addr !== 6'd0 || eng.req_valid !== 1'b0 || DONE !== 1'b0 ||
          C1X !== 4'd0 || C1Y !== 4'd0 || C2X !== 4'd0 || C2Y !== 4'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got we=%b addr=%0d req_valid=%b DONE=%b C1=(%0d,%0d) C2=(%0d,%0d), want all zero",
                  pt_we, pt_addr, eng.req_valid, DONE, C1X, C1Y, C2X, C2Y);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_load_and_first_request();
      mode = 0;
      load_points(1);
      @(negedge CLK);
      tests_run++;
      if (pt_we !== 1'b0 || eng.req_valid !== 1'b1 || eng.req_cx !== 4'd0 || eng.req_cy !== 4'd0 ||
          eng.req_ox !== 4'd15 || eng.req_oy !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL first_req: got we=%b valid=%b c=(%0d,%0d) o=(%0d,%0d), want we=0 valid=1 c=(0,0) o=(15,15)",
                  pt_we, eng.req_valid, eng.req_cx, eng.req_cy, eng.req_ox, eng.req_oy);
      end
   endtask

   task automatic test_single_peak();
      bit ok;
      wait_done(6000, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL peak_timeout: DONE=0 after 6000 cycles, want DONE=1");
         finish_run();
      end
      tests_run++;
      if (C1X !== 4'd5 || C1Y !== 4'd5 || C2X !== 4'd15 || C2Y !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL peak_result: got C1=(%0d,%0d) C2=(%0d,%0d), want C1=(5,5) C2=(15,15)", C1X, C1Y, C2X, C2Y);
      end
      tests_run++;
      if (req_num != 768) begin
         tests_failed++;
         $display("[TB] FAIL peak_reqs: got %0d requests, want 768", req_num);
      end
   endtask

   task automatic test_ties();
      bit ok;
      mode = 1;
      load_points(2);
      wait_done(6000, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL ties_timeout: DONE=0 after 6000 cycles, want DONE=1");
         finish_run();
      end
      tests_run++;
      if (C1X !== 4'd0 || C1Y !== 4'd0 || C2X !== 4'd15 || C2Y !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL ties_result: got C1=(%0d,%0d) C2=(%0d,%0d), want C1=(0,0) C2=(15,15)", C1X, C1Y, C2X, C2Y);
      end
      tests_run++;
      if (req_num != 768) begin
         tests_failed++;
         $display("[TB] FAIL ties_reqs: got %0d requests, want 768", req_num);
      end
   endtask

   task automatic test_pass_limit();
      bit ok;
      mode = 2;
      load_points(3);
      wait_done(12000, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL limit_timeout: DONE=0 after 12000 cycles, want DONE=1");
         finish_run();
      end
      tests_run++;
      if (C1X !== 4'd6 || C1Y !== 4'd6 || C2X !== 4'd7 || C2Y !== 4'd7) begin
         tests_failed++;
         $display("[TB] FAIL limit_result: got C1=(%0d,%0d) C2=(%0d,%0d), want C1=(6,6) C2=(7,7)", C1X, C1Y, C2X, C2Y);
      end
      tests_run++;
      if (req_num != 2048) begin
         tests_failed++;
         $display("[TB] FAIL limit_reqs: got %0d requests, want 2048", req_num);
      end
      for (int n = 0; n < 8; n++) begin
         coord_t eo;
         eo = (n == 0) ? 4'd15 : coord_t'(n - 1);
         tests_run++;
         if (other_x[n] !== eo || other_y[n] !== eo) begin
            tests_failed++;
            $display("[TB] FAIL limit_other_pass%0d: got o=(%0d,%0d), want o=(%0d,%0d)", n, other_x[n], other_y[n], eo, eo);
         end
      end
   endtask

   task automatic test_stalls();
      bit ok;
      mode = 0;
      stall_en = 1'b1;
      viol_outstanding = 0;
      viol_stable = 0;
      load_points(4);
      wait_done(15000, ok);
      stall_en = 1'b0;
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL stall_timeout: DONE=0 after 15000 cycles, want DONE=1");
         finish_run();
      end
      tests_run++;
      if (C1X !== 4'd5 || C1Y !== 4'd5 || C2X !== 4'd15 || C2Y !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL stall_result: got C1=(%0d,%0d) C2=(%0d,%0d), want C1=(5,5) C2=(15,15)", C1X, C1Y, C2X, C2Y);
      end
      tests_run++;
      if (req_num != 768) begin
         tests_failed++;
         $display("[TB] FAIL stall_reqs: got %0d requests, want 768", req_num);
      end
      tests_run++;
      if (viol_stable != 0) begin
         tests_failed++;
         $display("[TB] FAIL stall_hold: got %0d unstable stalled requests, want 0", viol_stable);
      end
      tests_run++;
      if (viol_outstanding != 0) begin
         tests_failed++;
         $display("[TB] FAIL stall_outstanding: got %0d overlapping requests, want 0", viol_outstanding);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int c;
      mode = 0;
      load_points(5);
      c = 0;
      while (req_num < 276 && c < 3000) begin
         @(negedge CLK);
         c++;
      end
      tests_run++;
      if (req_num < 276) begin
         tests_failed++;
         $display("[TB] FAIL midscan_reach: got %0d requests, want at least 276", req_num);
         finish_run();
      end
      #2 RST_N = 1'b0;
      #1;
      tests_run++;
      if (C1X !== 4'd0 || C1Y !== 4'd0 || C2X !== 4'd0 || C2Y !== 4'd0 || DONE !== 1'b0 ||
          pt_we !== 1'b0 || eng.req_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got C1=(%0d,%0d) C2=(%0d,%0d) DONE=%b we=%b valid=%b, want all zero",
                  C1X, C1Y, C2X, C2Y, DONE, pt_we, eng.req_valid);
      end
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      load_points(6);
      wait_done(6000, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL b2b_timeout: DONE=0 after 6000 cycles, want DONE=1");
         finish_run();
      end
      tests_run++;
      if (C1X !== 4'd5 || C1Y !== 4'd5 || C2X !== 4'd15 || C2Y !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL b2b_result: got C1=(%0d,%0d) C2=(%0d,%0d), want C1=(5,5) C2=(15,15)", C1X, C1Y, C2X, C2Y);
      end
      load_points(7);
      @(negedge CLK);
      tests_run++;
      if (eng.req_valid !== 1'b1 || eng.req_cx !== 4'd0 || eng.req_cy !== 4'd0 ||
          C1X !== 4'd5 || C2X !== 4'd15) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first_req: got valid=%b c=(%0d,%0d) C1X=%0d C2X=%0d, want valid=1 c=(0,0) C1X=5 C2X=15",
                  eng.req_valid, eng.req_cx, eng.req_cy, C1X, C2X);
      end
   endtask

   initial begin
      test_reset();
      test_load_and_first_request();
      test_single_peak();
      test_ties();
      test_pass_limit();
      test_stalls();
      test_back_to_back();
      finish_run();
   end

endmodule
